instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch initiator for the MIPS core: it owns the program counter, drives word addresses into the synchronous `instruction_memory` read port and hands fetched words plus their PCs to decode. It implements MIPS branch-delay-slot semantics, a decode stall, and the coursework halt convention: a jump to address 0 ends execution once the delay slot has been delivered.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC00000, first address fetched after reset.
- `HALT_ADDR`, 32'h00000000, redirect target that ends execution.

Ports:
- `clk`  in  1  system clock, all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_address`  out  32  byte address to instruction memory, always word-aligned.
- `instr_readdata`  in  32  memory data for the address presented on the previous clock edge.
- `stall`  in  1  decode cannot accept the current word; freeze fetch.
- `redirect_valid`  in  1  current `instr_word` is a taken branch or jump.
- `redirect_target`  in  32  its target byte address.
- `instr_valid`  out  1  `instr_word`/`instr_pc` hold a real instruction.
- `instr_word`  out  32  fetched instruction, equal to `instr_readdata`.
- `instr_pc`  out  32  address of `instr_word`.
- `active`  out  1  high until halt or fault.
- `fault`  out  1  sticky; set by a misaligned redirect target.

## Operation
- State machine in `fetch_pkg::fetch_state_t`:
  - RUN: normal fetch.
  - DRAIN: a halt or fault target has been accepted; the delay slot is on the output.
  - HALTED: fetch stopped normally.
  - FAULTED: fetch stopped by a misaligned target.
- Reset (async, `reset_n`=0) forces:
  - state RUN, `instr_address`=RESET_VECTOR, `instr_pc`=RESET_VECTOR;
  - `instr_valid`=0, `active`=1, `fault`=0.
- RUN, `stall`=0, each edge:
  - `instr_pc`<=`instr_address`, `instr_valid`<=1.
  - `instr_address`<=`instr_address`+4 (modulo 2^32 wrap).
  - If `redirect_valid` is high, `instr_address`<=`redirect_target` instead.
- Delay slot is natural: when decode sees a branch at P, address P+4 is already issued. P+4 is always delivered before the target.
- Redirect to HALT_ADDR: `instr_address` holds its value and the next state is DRAIN. The delay slot is delivered with `instr_valid`=1.
- Redirect target with bits [1:0]!=0: same as halt, but the next state after DRAIN is FAULTED.
- DRAIN, `stall`=0: next state HALTED or FAULTED, `instr_valid`<=0.
- `active`<=0 on entry to either terminal state; `fault`<=1 on entry to FAULTED.
- `redirect_valid` in DRAIN is ignored (a branch in a delay slot is undefined).
- HALTED and FAULTED are absorbing until reset. In these states all outputs hold and `instr_valid`=0.
- `stall`=1 (any state):
  - all registers hold;
  - `redirect_valid` is not sampled, so decode keeps it asserted until the stall is released;
  - the memory re-reads the held address, so `instr_word` stays stable.

## Timing
- Fetch latency is 1 cycle: address issued in cycle N appears on `instr_word` in cycle N+1.
- First valid word appears in the cycle after the first rising edge following reset release.
- Throughput is one word per unstalled cycle. A taken branch costs 0 bubbles (the delay slot fills them).
- `instr_word` is combinational from `instr_readdata`. All other outputs are registered.
- Stall and redirect in the same cycle: stall wins and the redirect is deferred.
- `reset_n` asserted mid-DRAIN or mid-stall aborts immediately to the reset values. There is no partial delivery.

## Structure
- `fetch_pkg` contains `fetch_state_t`, the default RESET_VECTOR and HALT_ADDR constants, and `WORD_BYTES`=4.
- One sub-module, `fetch_pc_reg`: the PC register with next-PC mux (increment / redirect / hold), async active-low reset to RESET_VECTOR.
- The top-level `instr_fetch` holds the FSM, output registers and the alignment check.

## Test plan
- Reset release with the ROM loaded from an addiu test image:
  - `instr_address` = BFC00000, then BFC00004, then BFC00008;
  - `instr_valid` rises 1 cycle after release with `instr_pc`=BFC00000.
- `stall` held 3 cycles while `instr_pc`=BFC00004: `instr_pc`, `instr_word` and `instr_address` are unchanged for 3 cycles, then advance by 4.
- Redirect at `instr_pc`=BFC00008, target BFC00100: the delivered PC sequence is BFC00008, BFC0000C (delay slot), BFC00100, BFC00104.
- `jr` to 0 at BFC00010:
  - BFC00014 is delivered;
  - next cycle `instr_valid`=0 and `active`=0, `fault`=0;
  - outputs stay frozen for 20 cycles.
- Redirect target BFC00102: the delay slot is delivered, then `fault`=1, `active`=0, `instr_valid`=0.
- Redirect with `stall`=1 for 2 cycles: the target is taken only on the first unstalled edge. `reset_n` pulsed low mid-DRAIN: `instr_address`=BFC00000 and `active`=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch block
//
// Purpose: fetch FSM state type, default reset vector / halt address,
//          instruction word size and a target alignment helper.
// Ports:   none (package).
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_FAULTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES           = 32'd4;

  // A fetch target must be word-aligned; any low address bit set is a fault.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with next-PC mux
//
// Purpose: holds the fetch address; each enabled edge it either
//          increments by one word or loads a redirect target.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, loads RESET_VECTOR
//   hold     in   keep the current PC (stall, halt request, terminal states)
//   load     in   take target instead of PC+4 (ignored while hold is high)
//   target   in   redirect byte address
//   pc       out  current fetch byte address
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_VECTOR;
    end else if (!hold) begin
      pc <= load ? target : pc + WORD_BYTES;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction-fetch initiator with delay slot and halt
//
// Purpose: owns the PC, drives the synchronous instruction memory and hands
//          fetched words with their PCs to decode. A redirect to HALT_ADDR
//          (or to a misaligned target) delivers the delay slot then stops.
// Ports:
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   instr_address    out  word-aligned byte address to instruction memory
//   instr_readdata   in   memory data for the previously issued address
//   stall            in   decode cannot accept the current word; freeze
//   redirect_valid   in   current instr_word is a taken branch/jump
//   redirect_target  in   its target byte address
//   instr_valid      out  instr_word/instr_pc hold a real instruction
//   instr_word       out  fetched instruction (passthrough of instr_readdata)
//   instr_pc         out  address of instr_word
//   active           out  high until halt or fault
//   fault            out  sticky misaligned-target flag
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic        active,
  output logic        fault
);

  fetch_state_t state;
  logic         fault_pending;
  logic         target_bad;
  logic         term_req;
  logic         pc_hold;

  // Halt and fault targets are never issued to memory: the PC freezes on the
  // delay-slot address while that slot is delivered.
  assign target_bad = is_misaligned(redirect_target);
  assign term_req   = redirect_valid && ((redirect_target == HALT_ADDR) || target_bad);
  assign pc_hold    = stall || (state != ST_RUN) || term_req;

  fetch_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk    (clk),
    .reset_n(reset_n),
    .hold   (pc_hold),
    .load   (redirect_valid),
    .target (redirect_target),
    .pc     (instr_address)
  );

  assign instr_word = instr_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_RUN;
      instr_pc      <= RESET_VECTOR;
      instr_valid   <= 1'b0;
      active        <= 1'b1;
      fault         <= 1'b0;
      fault_pending <= 1'b0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          instr_pc    <= instr_address;
          instr_valid <= 1'b1;
          if (term_req) begin
            state         <= ST_DRAIN;
            fault_pending <= target_bad;
          end
        end
        ST_DRAIN: begin
          // Redirects here would come from a branch in a delay slot: ignored.
          instr_valid <= 1'b0;
          active      <= 1'b0;
          if (fault_pending) begin
            state <= ST_FAULTED;
            fault <= 1'b1;
          end else begin
            state <= ST_HALTED;
          end
        end
        default: begin
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        active;
  logic        fault;

  int compared = 0;
  int mismatched = 0;

  instr_fetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_valid    (instr_valid),
    .instr_word     (instr_word),
    .instr_pc       (instr_pc),
    .active         (active),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // addiu-style image: each word encodes the low half of its own address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h2442_0000 | {16'h0000, a[15:0]};
  endfunction

  // Synchronous ROM; the decode stall also freezes the read register so the
  // word under decode is stable.
  always @(posedge clk) begin
    if (!stall) instr_readdata <= rom(instr_address);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_pc_word(input string tag, input logic [31:0] pc);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_word"}, instr_word, rom(pc));
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    do_reset();
    // Reset values, before any edge after release.
    check("rst_addr", instr_address, 32'hBFC00000);
    check("rst_pc", instr_pc, 32'hBFC00000);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd1);
    check("rst_fault", {31'd0, fault}, 32'd0);

    step();
    check("e1_addr", instr_address, 32'hBFC00004);
    check_pc_word("e1", 32'hBFC00000);
    step();
    check("e2_addr", instr_address, 32'hBFC00008);
    check_pc_word("e2", 32'hBFC00004);

    // Stall three cycles at PC BFC00004.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", instr_address, 32'hBFC00008);
      check_pc_word("stall", 32'hBFC00004);
    end
    stall = 1'b0;
    step();
    check("unstall_addr", instr_address, 32'hBFC0000C);
    check_pc_word("unstall", 32'hBFC00008);

    // Branch at BFC00008 to BFC00100: delay slot BFC0000C first.
    redirect_valid = 1'b1;
    redirect_target = 32'hBFC00100;
    step();
    redirect_valid = 1'b0;
    check_pc_word("br_slot", 32'hBFC0000C);
    check("br_addr", instr_address, 32'hBFC00100);
    step();
    check_pc_word("br_tgt", 32'hBFC00100);
    step();
    check_pc_word("br_tgt4", 32'hBFC00104);
    check("br_addr2", instr_address, 32'hBFC00108);

    // Redirect held under a 2-cycle stall is deferred.
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'hBFC00200;
    for (int i = 0; i < 2; i++) begin
      step();
      check("srd_pc", instr_pc, 32'hBFC00104);
      check("srd_addr", instr_address, 32'hBFC00108);
    end
    stall = 1'b0;
    step();
    redirect_valid = 1'b0;
    check_pc_word("srd_slot", 32'hBFC00108);
    check("srd_addr2", instr_address, 32'hBFC00200);
    step();
    check_pc_word("srd_tgt", 32'hBFC00200);

    // jr to 0 at BFC00010.
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("jr_pc_pre", instr_pc, 32'hBFC00010);
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    check_pc_word("jr_slot", 32'hBFC00014);
    check("jr_active_drain", {31'd0, active}, 32'd1);
    step();
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_active", {31'd0, active}, 32'd0);
    check("halt_fault", {31'd0, fault}, 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'hBFC00300;
    for (int i = 0; i < 20; i++) begin
      step();
      check("frz_addr", instr_address, 32'hBFC00014);
      check("frz_pc", instr_pc, 32'hBFC00014);
      check("frz_flags", {29'd0, instr_valid, active, fault}, 32'd0);
    end
    redirect_valid = 1'b0;

    // Reset pulsed mid-DRAIN acts without a clock edge.
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("md_addr_hold", instr_address, 32'hBFC00008);
    reset_n = 1'b0;
    #1;
    check("md_addr", instr_address, 32'hBFC00000);
    check("md_active", {31'd0, active}, 32'd1);
    check("md_valid", {31'd0, instr_valid}, 32'd0);

    // Misaligned target faults after the delay slot.
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'hBFC00102;
    step();
    redirect_valid = 1'b0;
    check_pc_word("mis_slot", 32'hBFC00004);
    check("mis_fault_drain", {31'd0, fault}, 32'd0);
    step();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_active", {31'd0, active}, 32'd0);
    check("mis_valid", {31'd0, instr_valid}, 32'd0);
    step();
    check("mis_sticky", {31'd0, fault}, 32'd1);
    check("mis_addr", instr_address, 32'hBFC00004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
